// File: rtl/icache_sa.sv
// icache_sa: N-way set-associative I-cache, true-LRU, multi-beat refill.
// Define ICACHE_SA_STATS_EN to add saturating hitcount/misscount outputs.
module icache_sa #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int WAYS           = 2,
  parameter int SETS           = 4,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ireq,
  input  logic [ADDR_W-1:0] instraddress,
  input  logic [DATA_W-1:0] ifetch,
  input  logic              iready,
  output logic [DATA_W-1:0] instruction,
  output logic              ivalid,
  output logic              hit,
  output logic              miss,
  output logic              fetchreq,
  output logic [ADDR_W-1:0] fetchaddr,
`ifdef ICACHE_SA_STATS_EN
  output logic [31:0]       hitcount,
  output logic [31:0]       misscount,
`endif
  output logic              busy
);
  localparam int OB = $clog2(WORDS_PER_LINE);
  localparam int IB = $clog2(SETS);
  localparam int TB = ADDR_W - OB - IB;
  localparam int AB = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [AB-1:0] AGE_MAX = AB'(WAYS - 1);
  localparam logic [OB-1:0] LAST_BEAT = OB'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {
    S_IDLE, S_LOOKUP, S_REFILL, S_RESPOND
  } state_e;

  state_e state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [OB-1:0] beat_q, beat_d;
  logic [AB-1:0] victim_q, victim_d;
  logic [DATA_W-1:0] word_q, word_d;

  logic valid_q [WAYS][SETS];
  logic valid_d [WAYS][SETS];
  logic [AB-1:0] age_q [WAYS][SETS];
  logic [AB-1:0] age_d [WAYS][SETS];
  logic [TB-1:0] tag_q [WAYS][SETS];
  logic [TB-1:0] tag_d [WAYS][SETS];
  logic [DATA_W-1:0] data_q [WAYS][SETS][WORDS_PER_LINE];
  logic [DATA_W-1:0] data_d [WAYS][SETS][WORDS_PER_LINE];

  logic [OB-1:0] off;
  logic [IB-1:0] idx;
  logic [TB-1:0] tg;
  assign off = addr_q[OB-1:0];
  assign idx = addr_q[OB +: IB];
  assign tg  = addr_q[ADDR_W-1 -: TB];

  logic hit_any, inv_any;
  logic [AB-1:0] hit_way, inv_way, lru_way, lru_age;
  logic promote;
  logic [AB-1:0] pway;

  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    inv_any = 1'b0;
    inv_way = '0;
    lru_way = '0;
    lru_age = age_q[0][idx];
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[w][idx] && tag_q[w][idx] == tg) begin
        hit_any = 1'b1;
        hit_way = AB'(w);
      end
      if (age_q[w][idx] > lru_age) begin
        lru_age = age_q[w][idx];
        lru_way = AB'(w);
      end
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[w][idx]) begin
        inv_any = 1'b1;
        inv_way = AB'(w);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    beat_d      = beat_q;
    victim_d    = victim_q;
    word_d      = word_q;
    valid_d     = valid_q;
    tag_d       = tag_q;
    data_d      = data_q;
    promote     = 1'b0;
    pway        = '0;
    instruction = '0;
    ivalid      = 1'b0;
    hit         = 1'b0;
    miss        = 1'b0;
    fetchreq    = 1'b0;
    fetchaddr   = '0;
    busy        = (state_q != S_IDLE);
    unique case (state_q)
      S_IDLE: begin
        if (ireq) begin
          addr_d  = instraddress;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (hit_any) begin
          hit         = 1'b1;
          ivalid      = 1'b1;
          instruction = data_q[hit_way][idx][off];
          promote     = 1'b1;
          pway        = hit_way;
          state_d     = S_IDLE;
        end else begin
          miss     = 1'b1;
          victim_d = inv_any ? inv_way : lru_way;
          // Victim data is overwritten beat by beat, so drop it now.
          valid_d[victim_d][idx] = 1'b0;
          beat_d   = '0;
          state_d  = S_REFILL;
        end
      end
      S_REFILL: begin
        fetchreq  = 1'b1;
        fetchaddr = {tg, idx, beat_q};
        if (iready) begin
          data_d[victim_q][idx][beat_q] = ifetch;
          if (beat_q == off) word_d = ifetch;
          beat_d = beat_q + OB'(1);
          if (beat_q == LAST_BEAT) begin
            valid_d[victim_q][idx] = 1'b1;
            tag_d[victim_q][idx]   = tg;
            promote = 1'b1;
            pway    = victim_q;
            state_d = S_RESPOND;
          end
        end
      end
      S_RESPOND: begin
        ivalid      = 1'b1;
        instruction = word_q;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Ways at or below the promoted age step up (saturating) so that
  // equal post-reset ages separate into a strict order.
  always_comb begin
    age_d = age_q;
    if (promote) begin
      for (int w = 0; w < WAYS; w++) begin
        if (AB'(w) == pway)
          age_d[w][idx] = '0;
        else if (age_q[w][idx] <= age_q[pway][idx] &&
                 age_q[w][idx] != AGE_MAX)
          age_d[w][idx] = age_q[w][idx] + AB'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      beat_q   <= '0;
      victim_q <= '0;
      word_q   <= '0;
      valid_q  <= '{default: 1'b0};
      age_q    <= '{default: '0};
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      beat_q   <= beat_d;
      victim_q <= victim_d;
      word_q   <= word_d;
      valid_q  <= valid_d;
      age_q    <= age_d;
    end
  end

  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

`ifdef ICACHE_SA_STATS_EN
  logic [31:0] hitcount_q, hitcount_d;
  logic [31:0] misscount_q, misscount_d;

  always_comb begin
    hitcount_d  = hitcount_q;
    misscount_d = misscount_q;
    if (hit && hitcount_q != '1) hitcount_d = hitcount_q + 32'd1;
    if (miss && misscount_q != '1) misscount_d = misscount_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hitcount_q  <= '0;
      misscount_q <= '0;
    end else begin
      hitcount_q  <= hitcount_d;
      misscount_q <= misscount_d;
    end
  end

  assign hitcount  = hitcount_q;
  assign misscount = misscount_q;
`endif
endmodule

// File: tb/tb_icache_sa.sv
// tb_icache_sa: directed scoreboard bench for icache_sa (default params).
// Checks hit/miss, refill addresses, delivered words, latency and reset abort.
module tb_icache_sa;
  logic clk = 1'b0;
  logic reset, ireq, iready;
  logic [31:0] instraddress, ifetch;
  logic [31:0] instruction, fetchaddr;
  logic ivalid, hit, miss, fetchreq, busy;
`ifdef ICACHE_SA_STATS_EN
  logic [31:0] hitcount, misscount;
`endif

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic        h;
    logic [31:0] w;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  logic last_hit = 1'b0;
  int resp_cnt = 0;
  logic [31:0] beat_base = '0;
  int beat_tb = 0;
  bit pat[$];
  int pi = 0;

  icache_sa dut (
    .clk(clk),
    .reset(reset),
    .ireq(ireq),
    .instraddress(instraddress),
    .ifetch(ifetch),
    .iready(iready),
    .instruction(instruction),
    .ivalid(ivalid),
    .hit(hit),
    .miss(miss),
    .fetchreq(fetchreq),
    .fetchaddr(fetchaddr),
`ifdef ICACHE_SA_STATS_EN
    .hitcount(hitcount),
    .misscount(misscount),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return 32'h1000_0000 + a - 32'h8;
  endfunction

  // Memory responder: beat strobes follow pat (all ones if empty).
  always @(posedge clk) begin
    #1;
    if (fetchreq) begin
      iready = (pat.size() == 0) ? 1'b1 : pat[pi % pat.size()];
      pi++;
      ifetch = iready ? mem(fetchaddr) : 32'hDEAD_BEEF;
    end else begin
      iready = 1'b0;
      ifetch = 32'hDEAD_BEEF;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (hit || miss) begin
        checks++;
        assert ((hit & miss) === 1'b0) else begin
          failures++;
          $error("FAIL hit_miss_excl hit=%b miss=%b", hit, miss);
        end
        last_hit = hit;
      end
      if (fetchreq && iready) begin
        checks++;
        assert (fetchaddr === beat_base + beat_tb) else begin
          failures++;
          $error("FAIL fetchaddr obs=%h exp=%h", fetchaddr,
                 beat_base + beat_tb);
        end
        beat_tb++;
      end
      if (ivalid) begin
        resp_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $error("FAIL unexpected_ivalid obs=%h exp=none", instruction);
        end else begin
          mon_e = exp_q.pop_front();
          assert (instruction === mon_e.w) else begin
            failures++;
            $error("FAIL instruction obs=%h exp=%h", instruction, mon_e.w);
          end
          checks++;
          assert (last_hit === mon_e.h) else begin
            failures++;
            $error("FAIL hit_flag obs=%b exp=%b", last_hit, mon_e.h);
          end
        end
      end
    end
  end

  task automatic req(input logic [31:0] a, input logic eh,
                     input int exp_lat);
    int n;
    int r0;
    exp_q.push_back('{h: eh, w: mem(a)});
    beat_base = a & ~32'h3;
    beat_tb = 0;
    pi = 0;
    r0 = resp_cnt;
    ireq = 1'b1;
    instraddress = a;
    @(posedge clk);
    #1;
    ireq = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (busy && n < 50);
    checks++;
    assert (n === exp_lat) else begin
      failures++;
      $error("FAIL latency addr=%h obs=%0d exp=%0d", a, n, exp_lat);
    end
    checks++;
    assert (resp_cnt === r0 + 1) else begin
      failures++;
      $error("FAIL ivalid_count addr=%h obs=%0d exp=%0d", a,
             resp_cnt - r0, 1);
    end
  endtask

  initial begin
    int n;
    reset = 1'b1;
    ireq = 1'b0;
    instraddress = '0;
    iready = 1'b0;
    ifetch = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    assert ({instruction, fetchaddr, ivalid, hit, miss, fetchreq, busy}
            === 69'd0) else begin
      failures++;
      $error("FAIL reset_outputs obs=%h/%h/%b%b%b%b%b exp=0", instruction,
             fetchaddr, ivalid, hit, miss, fetchreq, busy);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;

    req(32'h08, 1'b0, 6);
    req(32'h09, 1'b1, 1);
    req(32'h0B, 1'b1, 1);
    req(32'h0C, 1'b0, 6);
`ifdef ICACHE_SA_STATS_EN
    checks++;
    assert ({hitcount, misscount} === {32'd2, 32'd2}) else begin
      failures++;
      $error("FAIL stats obs=%0d/%0d exp=2/2", hitcount, misscount);
    end
`endif

    req(32'h28, 1'b0, 6);
    req(32'h08, 1'b1, 1);
    req(32'h48, 1'b0, 6);
    req(32'h28, 1'b0, 6);
    req(32'h08, 1'b0, 6);
    req(32'h0A, 1'b1, 1);

    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    req(32'h12, 1'b0, 9);
    pat.delete();
    req(32'h11, 1'b1, 1);

    beat_base = 32'h30;
    beat_tb = 0;
    pi = 0;
    ireq = 1'b1;
    instraddress = 32'h31;
    @(posedge clk);
    #1;
    ireq = 1'b0;
    n = 0;
    while (beat_tb < 2 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    assert (beat_tb === 2) else begin
      failures++;
      $error("FAIL abort_beats obs=%0d exp=%0d", beat_tb, 2);
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    assert ({instruction, fetchaddr, ivalid, hit, miss, fetchreq, busy}
            === 69'd0) else begin
      failures++;
      $error("FAIL abort_outputs obs=%h/%h/%b%b%b%b%b exp=0", instruction,
             fetchaddr, ivalid, hit, miss, fetchreq, busy);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    req(32'h31, 1'b0, 6);
    req(32'h08, 1'b0, 6);
    req(32'h33, 1'b1, 1);

    checks++;
    assert (exp_q.size() === 0) else begin
      failures++;
      $error("FAIL pending_expect obs=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
